// File: rtl/player_r_motion_if.sv
// Player-right motion bus: raw button/vsync inputs toward the motion block
// and the registered position/status back from it.
//   left, right, vsync_in : raw asynchronous inputs (driven by master)
//   RP_x_pos [11:0]       : position offset, screen x = 885 - RP_x_pos
//   moving, at_limit      : registered status flags
interface player_r_motion_if;
  logic        left;
  logic        right;
  logic        vsync_in;
  logic [11:0] RP_x_pos;
  logic        moving;
  logic        at_limit;

  modport master (
    output left, right, vsync_in,
    input  RP_x_pos, moving, at_limit
  );

  modport slave (
    input  left, right, vsync_in,
    output RP_x_pos, moving, at_limit
  );
endinterface

// File: rtl/player_r_motion.sv
// Right-player horizontal motion: synchronizes raw buttons and vsync,
// debounces the buttons on frame ticks, and steps the position offset
// through an IDLE/MOVE_L/MOVE_R FSM clamped to [0, RP_MAX].
// Ports:
//   clk    : single clock, all state on rising edge
//   reset  : asynchronous active-low reset
//   bus_if : slave side of player_r_motion_if (left/right/vsync_in in,
//            RP_x_pos/moving/at_limit out, all outputs registered)
// Optional feature macro: PLAYER_R_ACCEL_EN (frame hold counter driving a
// 1/2/4 accelerating step instead of the fixed STEP).
module player_r_motion #(
  parameter int unsigned RP_INIT    = 100,
  parameter int unsigned RP_MAX     = 600,
  parameter int unsigned STEP       = 2,
  parameter int unsigned DEB_FRAMES = 2
) (
  input  logic                clk,
  input  logic                reset,
  player_r_motion_if.slave    bus_if
);

  localparam int unsigned PW = 12;
  localparam int unsigned AW = 13;
  localparam int unsigned CW = $clog2(DEB_FRAMES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MOVE_L = 2'd1;
  localparam logic [1:0] MOVE_R = 2'd2;

  localparam logic LIM_INIT = (RP_INIT == 0) || (RP_INIT == RP_MAX);

  logic [1:0]    left_sync_q, right_sync_q, vs_sync_q;
  logic          vs_hist_q;
  logic [1:0]    prime_q;
  logic          deb_l_q, deb_r_q, deb_l_d, deb_r_d;
  logic [CW-1:0] cnt_l_q, cnt_r_q, cnt_l_d, cnt_r_d;
  logic [1:0]    state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic          moving_q, moving_d;
  logic          at_limit_q, at_limit_d;
  logic          tick_c;
  logic [AW-1:0] step_c;
  logic [AW-1:0] pos_ext_c;
  logic [AW-1:0] sum_c;

  // History flop resets high and only tracks vsync once the synchronizer
  // has refilled, so a vsync already high at reset release is not a tick.
  assign tick_c = prime_q[1] & vs_sync_q[1] & ~vs_hist_q;

  // Synchronizers and frame edge detector
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left_sync_q  <= '0;
      right_sync_q <= '0;
      vs_sync_q    <= '0;
      vs_hist_q    <= 1'b1;
      prime_q      <= '0;
    end else begin
      left_sync_q  <= {left_sync_q[0], bus_if.left};
      right_sync_q <= {right_sync_q[0], bus_if.right};
      vs_sync_q    <= {vs_sync_q[0], bus_if.vsync_in};
      prime_q      <= {prime_q[0], 1'b1};
      vs_hist_q    <= prime_q[1] ? vs_sync_q[1] : 1'b1;
    end
  end

  // Per-button debounce: DEB_FRAMES consecutive ticks of the new value
  always_comb begin
    cnt_l_d = cnt_l_q;
    cnt_r_d = cnt_r_q;
    deb_l_d = deb_l_q;
    deb_r_d = deb_r_q;
    if (tick_c) begin
      if (left_sync_q[1] != deb_l_q) begin
        if (32'(cnt_l_q) + 32'd1 >= DEB_FRAMES) begin
          deb_l_d = left_sync_q[1];
          cnt_l_d = '0;
        end else begin
          cnt_l_d = cnt_l_q + CW'(1);
        end
      end else begin
        cnt_l_d = '0;
      end
      if (right_sync_q[1] != deb_r_q) begin
        if (32'(cnt_r_q) + 32'd1 >= DEB_FRAMES) begin
          deb_r_d = right_sync_q[1];
          cnt_r_d = '0;
        end else begin
          cnt_r_d = cnt_r_q + CW'(1);
        end
      end else begin
        cnt_r_d = '0;
      end
    end
  end

  // Next state from the debounced levels held before this tick
  always_comb begin
    state_d = state_q;
    if (tick_c) begin
      case ({deb_l_q, deb_r_q})
        2'b10:   state_d = MOVE_L;
        2'b01:   state_d = MOVE_R;
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef PLAYER_R_ACCEL_EN
  logic [5:0] hold_q, hold_d;

  // Hold counter restarts on a state change; step grows with hold time
  always_comb begin
    hold_d = hold_q;
    step_c = AW'(1);
    if (tick_c) begin
      if (state_d != state_q) begin
        hold_d = '0;
        step_c = AW'(1);
      end else begin
        hold_d = (hold_q >= 6'd32) ? 6'd32 : hold_q + 6'd1;
        if (hold_q >= 6'd32)      step_c = AW'(4);
        else if (hold_q >= 6'd16) step_c = AW'(2);
        else                      step_c = AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  assign step_c = AW'(STEP);
`endif

  // Position update with 13-bit headroom, clamped to [0, RP_MAX]
  always_comb begin
    pos_ext_c  = {1'b0, pos_q};
    sum_c      = pos_ext_c + step_c;
    pos_d      = pos_q;
    moving_d   = moving_q;
    at_limit_d = at_limit_q;
    if (tick_c) begin
      case (state_d)
        MOVE_L:  pos_d = (sum_c > AW'(RP_MAX)) ? PW'(RP_MAX) : PW'(sum_c);
        MOVE_R:  pos_d = (pos_ext_c >= step_c) ? PW'(pos_ext_c - step_c) : '0;
        default: pos_d = pos_q;
      endcase
      moving_d   = (state_d == MOVE_L) || (state_d == MOVE_R);
      at_limit_d = (pos_d == '0) || (pos_d == PW'(RP_MAX));
    end
  end

  // Debounce, FSM and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_l_q    <= '0;
      cnt_r_q    <= '0;
      deb_l_q    <= 1'b0;
      deb_r_q    <= 1'b0;
      state_q    <= IDLE;
      pos_q      <= PW'(RP_INIT);
      moving_q   <= 1'b0;
      at_limit_q <= LIM_INIT;
    end else begin
      cnt_l_q    <= cnt_l_d;
      cnt_r_q    <= cnt_r_d;
      deb_l_q    <= deb_l_d;
      deb_r_q    <= deb_r_d;
      state_q    <= state_d;
      pos_q      <= pos_d;
      moving_q   <= moving_d;
      at_limit_q <= at_limit_d;
    end
  end

  assign bus_if.RP_x_pos = pos_q;
  assign bus_if.moving   = moving_q;
  assign bus_if.at_limit = at_limit_q;

endmodule
